// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and the keyboard
// receiver path.
//   ps2_state_t     transmitter FSM states
//   ERR_*           err_code values reported with the err pulse
//   CMD_*           common host-to-keyboard command bytes
//   odd_parity()    PS/2 odd parity bit for a data byte
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    START   = 3'd2,
    DATA    = 3'd3,
    PARITY  = 3'd4,
    STOP    = 3'd5,
    ACK     = 3'd6
  } ps2_state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;
  localparam logic [1:0] ERR_RELEASE = 2'b11;

  localparam logic [7:0] CMD_LED       = 8'hED;
  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw PS2_CLK / PS2_DAT pins into the clk domain
// and reports device clock falling edges.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   clk_pin   raw PS2_CLK pin
//   dat_pin   raw PS2_DAT pin
//   clk_lvl   synchronized (optionally filtered) clock level
//   dat_lvl   synchronized data level
//   clk_fall  one-cycle pulse, registered, after clk_lvl goes 1 -> 0
// Build option PS2_TX_CLK_FILTER_EN: clk_lvl only follows the synchronized
// clock after 4 agreeing samples, rejecting glitches shorter than 4 cycles.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_lvl,
  output logic dat_lvl,
  output logic clk_fall
);

  logic clk_p0, clk_p1;
  logic dat_p0, dat_p1;
  logic clk_src;
  logic clk_prev_p2, fall_p2;

  // Stage p0/p1: two-flop synchronizers; idle PS/2 lines read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0 <= 1'b1;
      clk_p1 <= 1'b1;
      dat_p0 <= 1'b1;
      dat_p1 <= 1'b1;
    end else begin
      clk_p0 <= clk_pin;
      clk_p1 <= clk_p0;
      dat_p0 <= dat_pin;
      dat_p1 <= dat_p0;
    end
  end

`ifdef PS2_TX_CLK_FILTER_EN
  logic [3:0] flt_sh;
  logic       flt_lvl;

  // Filter stage: the level moves only when the last 4 samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_sh  <= 4'hF;
      flt_lvl <= 1'b1;
    end else begin
      flt_sh <= {flt_sh[2:0], clk_p1};
      if (flt_sh == 4'hF) begin
        flt_lvl <= 1'b1;
      end else if (flt_sh == 4'h0) begin
        flt_lvl <= 1'b0;
      end
    end
  end

  assign clk_src = flt_lvl;
`else
  assign clk_src = clk_p1;
`endif

  // Stage p2: registered falling-edge detect, one cycle after the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_p2 <= 1'b1;
      fall_p2     <= 1'b0;
    end else begin
      clk_prev_p2 <= clk_src;
      fall_p2     <= clk_prev_p2 & ~clk_src;
    end
  end

  assign clk_lvl  = clk_src;
  assign dat_lvl  = dat_p1;
  assign clk_fall = fall_p2;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Sends one command byte
// (LSB first, odd parity, stop, device ack) to the keyboard over the
// open-drain PS2_CLK/PS2_DAT lines.
//   clk25       25 MHz system clock
//   reset_n     asynchronous active-low reset; releases both lines at once
//   tx_data     command byte, latched on acceptance
//   tx_valid    request; accepted when tx_valid && tx_ready
//   tx_ready    high only while idle
//   ps2_clk_i   raw PS2_CLK pin
//   ps2_dat_i   raw PS2_DAT pin
//   ps2_clk_oe  1 = pull PS2_CLK low, 0 = release
//   ps2_dat_oe  1 = pull PS2_DAT low, 0 = release
//   rx_inhibit  high while this block owns the bus
//   done        one-cycle pulse: byte acknowledged
//   err         one-cycle pulse: transfer failed
//   err_code    cause of the last err, held until the next err
// Build option PS2_TX_CLK_FILTER_EN enables the glitch filter in
// ps2_line_sync.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC   = 2600,
  parameter int TIMEOUT_CYC   = 375000,
  parameter int DONE_WAIT_CYC = 50000
) (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int MAX_AB  = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > DONE_WAIT_CYC) ? MAX_AB : DONE_WAIT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] DW_LOAD  = CNT_W'(DONE_WAIT_CYC - 1);

  logic clk_lvl, dat_lvl, clk_fall;

  ps2_line_sync u_sync (
    .clk      (clk25),
    .rst_n    (reset_n),
    .clk_pin  (ps2_clk_i),
    .dat_pin  (ps2_dat_i),
    .clk_lvl  (clk_lvl),
    .dat_lvl  (dat_lvl),
    .clk_fall (clk_fall)
  );

  ps2_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       idx, idx_nx;
  logic             nack, nack_nx;
  logic             done_nx, err_nx;
  logic [1:0]       code_nx;
  logic             load;
  logic [7:0]       data_q;
  logic             par_q;
  logic             line_bit, line_bit_nx;

  assign tx_ready   = (state == IDLE);
  assign rx_inhibit = (state != IDLE);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    idx_nx      = idx;
    nack_nx     = nack;
    line_bit_nx = line_bit;
    done_nx     = 1'b0;
    err_nx      = 1'b0;
    code_nx     = err_code;
    load        = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_dat_oe  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid) begin
          load     = 1'b1;
          nack_nx  = 1'b0;
          cnt_nx   = INH_LOAD;
          state_nx = INHIBIT;
        end
      end

      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt == '0) begin
          // Start bit overlaps the last inhibit cycle.
          ps2_dat_oe = 1'b1;
          cnt_nx     = TO_LOAD;
          state_nx   = START;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      START, DATA, PARITY, STOP: begin
        // line_bit holds the bit currently presented; 1 means released.
        if (state == START) begin
          ps2_dat_oe = 1'b1;
        end else if (state != STOP) begin
          ps2_dat_oe = ~line_bit;
        end

        // A device edge takes priority over a timeout in the same cycle.
        if (clk_fall) begin
          cnt_nx = TO_LOAD;
          case (state)
            START: begin
              line_bit_nx = data_q[0];
              idx_nx      = 4'd1;
              state_nx    = DATA;
            end
            DATA: begin
              if (idx == 4'd8) begin
                line_bit_nx = par_q;
                state_nx    = PARITY;
              end else begin
                line_bit_nx = data_q[idx[2:0]];
                idx_nx      = idx + 4'd1;
              end
            end
            PARITY: begin
              state_nx = STOP;
            end
            default: begin
              nack_nx  = dat_lvl;
              cnt_nx   = DW_LOAD;
              state_nx = ACK;
            end
          endcase
        end else if (cnt == '0) begin
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      ACK: begin
        if (clk_lvl && dat_lvl) begin
          state_nx = IDLE;
          if (nack) begin
            err_nx  = 1'b1;
            code_nx = ERR_NACK;
          end else begin
            done_nx = 1'b1;
          end
        end else if (cnt == '0) begin
          err_nx   = 1'b1;
          code_nx  = ERR_RELEASE;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      nack     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      nack     <= nack_nx;
      done     <= done_nx;
      err      <= err_nx;
      err_code <= code_nx;
    end
  end

  always_ff @(posedge clk25) begin
    if (load) begin
      data_q <= tx_data;
      par_q  <= odd_parity(tx_data);
    end
    line_bit <= line_bit_nx;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with a behavioural PS/2 keyboard
// model on open-drain lines. Parameters are shortened so the run stays small;
// the inhibit length keeps its real value.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 2600;
  localparam int TO  = 4000;
  localparam int DW  = 2000;

  logic       clk25 = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_inhibit, done, err;
  logic [1:0] err_code;
  logic       dev_clk_low, dev_dat_low;
  logic       clk_pin, dat_pin;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [1:0] last_code = 2'b00;

  always #20 clk25 = ~clk25;

  // Open-drain bus: anyone pulling low wins.
  assign clk_pin = !(ps2_clk_oe || dev_clk_low);
  assign dat_pin = !(ps2_dat_oe || dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC  (INH),
    .TIMEOUT_CYC  (TO),
    .DONE_WAIT_CYC(DW)
  ) dut (
    .clk25     (clk25),
    .reset_n   (reset_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_i (clk_pin),
    .ps2_dat_i (dat_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_inhibit(rx_inhibit),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  always @(negedge clk25) begin
    if (done) done_cnt++;
    if (err) begin
      err_cnt++;
      last_code = err_code;
    end
  end

  initial begin
    #8000000;
    $display("FAIL watchdog sim_time=%0t limit=8000000", $time);
    $fatal(1, "watchdog");
  end

  // Reference: PS/2 odd parity from a plain count of ones.
  function automatic logic ref_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic accept(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 50000) begin
      @(negedge clk25);
      n++;
    end
    total++;
    if (tx_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait tx_ready=%b want=1", tx_ready);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk25);
    tx_valid = 1'b0;
    total++;
    if (tx_ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_fall tx_ready=%b want=0", tx_ready);
    end
  endtask

  task automatic inhibit_phase(input bit chk);
    int n = 0;
    int dhi = 0;
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      if (ps2_dat_oe) dhi++;
      @(negedge clk25);
    end
    if (chk) begin
      total++;
      if (n != INH) begin
        bad++;
        $display("FAIL inhibit_len got=%0d want=%0d", n, INH);
      end
      total++;
      if (dhi != 1) begin
        bad++;
        $display("FAIL start_overlap got=%0d want=1", dhi);
      end
    end
    total++;
    if ({ps2_clk_oe, ps2_dat_oe, rx_inhibit} !== 3'b011) begin
      bad++;
      $display("FAIL start_lines clk_oe,dat_oe,inh=%b want=011",
               {ps2_clk_oe, ps2_dat_oe, rx_inhibit});
    end
  endtask

  // Keyboard model: clocks nfalls falling edges, samples the line while the
  // clock is low. Fall i presents bit i-1 (8 data, parity, stop). With
  // nfalls < 11 it returns holding the clock low.
  task automatic dev_run(input int half, input int nfalls, input bit ack,
                         input bit glitch, input bit poke,
                         output logic [9:0] bits);
    bits = '0;
    cyc(half);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      cyc(half / 2);
      if (i <= 10) bits[i-1] = dat_pin;
      if (i == nfalls && nfalls < 11) break;
      cyc(half - half / 2);
      dev_clk_low = 1'b0;
      if (i == 11) break;
      if (i == 10 && ack) begin
        cyc(10);
        dev_dat_low = 1'b1;
      end
      if (poke && i == 4) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
      end
      if (glitch && i >= 2 && i <= 7) begin
        cyc(half / 2);
        dev_clk_low = 1'b1;
        cyc(2);
        dev_clk_low = 1'b0;
      end
      cyc(half);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input int half, input bit ack,
                      input bit hold, input bit glitch, input bit poke,
                      input bit chk_inh);
    logic [9:0] bits;
    int n = 0;
    int d0 = done_cnt;
    int e0 = err_cnt;
    logic [1:0] code0 = err_code;
    bit want_done = ack && !hold;
    logic [1:0] want_code = !ack ? ERR_NACK : ERR_RELEASE;

    accept(b);
    inhibit_phase(chk_inh);
    dev_run(half, 11, ack, glitch, poke, bits);
    if (!hold) begin
      cyc(half / 2);
      dev_dat_low = 1'b0;
    end
    while ((done_cnt + err_cnt) == (d0 + e0) && n < DW + 600) begin
      @(negedge clk25);
      #1;
      n++;
    end
    cyc(5);
    #1;

    total++;
    if (bits[7:0] !== b) begin
      bad++;
      $display("FAIL data_bits got=%h want=%h", bits[7:0], b);
    end
    total++;
    if (bits[8] !== ref_parity(b)) begin
      bad++;
      $display("FAIL parity_bit byte=%h got=%b want=%b", b, bits[8], ref_parity(b));
    end
    total++;
    if (bits[9] !== 1'b1) begin
      bad++;
      $display("FAIL stop_bit got=%b want=1", bits[9]);
    end
    total++;
    if ((done_cnt - d0) != (want_done ? 1 : 0)) begin
      bad++;
      $display("FAIL done_pulses got=%0d want=%0d", done_cnt - d0, want_done ? 1 : 0);
    end
    total++;
    if ((err_cnt - e0) != (want_done ? 0 : 1)) begin
      bad++;
      $display("FAIL err_pulses got=%0d want=%0d", err_cnt - e0, want_done ? 0 : 1);
    end
    total++;
    if (want_done) begin
      if (err_code !== code0) begin
        bad++;
        $display("FAIL err_code_hold got=%b want=%b", err_code, code0);
      end
    end else if (last_code !== want_code) begin
      bad++;
      $display("FAIL err_code got=%b want=%b", last_code, want_code);
    end
    total++;
    if ({tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit} !== 4'b1000) begin
      bad++;
      $display("FAIL end_state rdy,clk_oe,dat_oe,inh=%b want=1000",
               {tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit});
    end
    if (hold) begin
      dev_dat_low = 1'b0;
      cyc(5);
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    total++;
    if ({tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe, done, err, err_code} !== 8'b1000_0000) begin
      bad++;
      $display("FAIL reset_state rdy,inh,coe,doe,done,err,code=%b want=10000000",
               {tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe, done, err, err_code});
    end
  endtask

  task automatic test_led();
    xfer(CMD_LED, 750, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_nack();
    xfer(8'h01, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int t = 0;
    accept(CMD_RESET);
    inhibit_phase(1'b0);
    while (!err && t < TO + 100) begin
      @(negedge clk25);
      t++;
    end
    total++;
    if (t != TO) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want=%0d", t, TO);
    end
    total++;
    if (err_code !== ERR_TIMEOUT) begin
      bad++;
      $display("FAIL timeout_code got=%b want=%b", err_code, ERR_TIMEOUT);
    end
    total++;
    if ({tx_ready, ps2_clk_oe, ps2_dat_oe} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_lines rdy,coe,doe=%b want=100", {tx_ready, ps2_clk_oe, ps2_dat_oe});
    end
    cyc(5);
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    accept(8'hA5);
    inhibit_phase(1'b0);
    dev_run(100, 5, 1'b0, 1'b0, 1'b0, bits);
    total++;
    if (bits[4:0] !== 5'b00101 || ps2_dat_oe !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset bits=%b dat_oe=%b want=00101/1", bits[4:0], ps2_dat_oe);
    end
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if ({ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL async_release coe,doe,inh,rdy=%b want=0001",
               {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready});
    end
    dev_clk_low = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    xfer(8'h00, 100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    xfer(CMD_TYPEMATIC, 100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk25);
      if (rx_inhibit || ps2_clk_oe) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL no_second_xfer busy_cycles=%0d want=0", seen);
    end
  endtask

  task automatic test_release_timeout();
    xfer(8'($urandom), 100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      xfer(8'($urandom), 100, ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

`ifdef PS2_TX_CLK_FILTER_EN
  task automatic test_filter();
    xfer(CMD_LED, 200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_led();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_release_timeout();
    test_random();
`ifdef PS2_TX_CLK_FILTER_EN
    test_filter();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the opposite direction of the existing keyboard receiver on PS2_CLK/PS2_DAT.
- Sends command bytes to the keyboard, e.g. 0xED LED set, 0xFF reset, 0xF3 typematic.
- Sits beside the receiver inside bk0010 and drives the PS/2 lines open-drain through top-level tristates.
- Asserts rx_inhibit while it owns the bus so the receiver ignores its own clocks.

Parameters:
- INHIBIT_CYC, 2600: clock-low hold before the start bit, in clk25 cycles (104 us).
- TIMEOUT_CYC, 375000: maximum wait for the first device clock edge, and also for each subsequent edge (15 ms).
- DONE_WAIT_CYC, 50000: maximum wait for the device to release both lines after the ack (2 ms).

Ports:
- clk25  in  1  system clock, 25 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_i  in  1  raw PS2_CLK pin.
- ps2_dat_i  in  1  raw PS2_DAT pin.
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- rx_inhibit  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: byte acknowledged by device.
- err  out  1  one-cycle pulse: transfer failed.
- err_code  out  2  valid with err, held until the next err. 01 = timeout, 10 = NACK, 11 = release timeout.

Behaviour:
- Reset, asynchronous: ps2_clk_oe=0, ps2_dat_oe=0, tx_ready=1, rx_inhibit=0, done=0, err=0, err_code=00, state=IDLE. Both lines are released immediately, including mid-transfer.
- Inputs pass through 2-flop synchronizers. clk_fall = synced clock was 1 and is now 0. Edge detect is 1 cycle after sync, so 3 cycles pin-to-action.
- Acceptance: tx_data is latched on acceptance. Odd parity = ~^tx_data. tx_valid outside IDLE is ignored, not queued.
- IDLE: both oe=0. On acceptance go to INHIBIT and load the counter.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYC cycles. In the last cycle set dat_oe=1 (start bit), then go to START.
- START: clk_oe=0, dat_oe=1. Counter reloads to TIMEOUT_CYC.
  - On clk_fall: dat_oe=~d[0], bit index=1, go to DATA.
- DATA: on each clk_fall, dat_oe=~d[idx] and idx increments.
  - After d[7] has been placed, the next clk_fall places parity (dat_oe=~parity), go to PARITY.
- PARITY: next clk_fall → dat_oe=0 (stop bit = released), go to STOP.
- STOP: next clk_fall → sample synced data, go to ACK.
  - Data 0: ACK good.
  - Data 1: flag NACK.
- ACK: wait until synced clock=1 and data=1, bounded by DONE_WAIT_CYC.
  - Then pulse done (or err with 10 if NACK flagged), go to IDLE.
  - Exceeding DONE_WAIT_CYC: err with 11, go to IDLE.
- Timeout: the counter reloads on every clk_fall in START/DATA/PARITY/STOP. Reaching 0 → both oe=0, err=1, err_code=01, go to IDLE.
- Bit order and count: LSB first. Exactly 11 device falling edges from START to ACK entry.
- Line driving: the block never drives a line high. oe=1 only ever means drive low.
- Simultaneous events: timeout expiry and clk_fall in the same cycle → clk_fall wins.
- tx_ready: falls the cycle after acceptance and rises the cycle done/err pulses.

Optional Feature:
- Macro: PS2_TX_CLK_FILTER_EN.
- Defined: the synced clock feeds a 4-sample shift register. The filtered clock changes only when all 4 samples agree; edge detect uses the filtered value. This rejects glitches shorter than 4 cycles (160 ns) and adds 4 cycles of latency.
- Undefined: edge detect uses the synchronizer output directly.
- All other behaviour is identical either way.

Decomposition:
- Shared package ps2_pkg:
  - state encoding (IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK);
  - err_code constants ERR_TIMEOUT=2'b01, ERR_NACK=2'b10, ERR_RELEASE=2'b11;
  - command constants CMD_LED=8'hED, CMD_RESET=8'hFF.
- One sub-module, ps2_line_sync: synchronizer plus optional filter plus falling-edge detect. The existing receiver can reuse it.

Test Plan:
- Send 0xED; a device model clocks at a 60 us period and acks low. Required:
  - clk_oe low for exactly 2600 cycles;
  - data bits on the line 1,0,1,1,0,1,1,1, parity 1, stop released;
  - done pulses once; tx_ready returns to 1.
- Send 0x01; device NACKs (data high at the 11th fall). Required: parity bit 0, err=1 with err_code=10, both oe=0.
- Send 0xFF; device never clocks. Required: err_code=01 exactly TIMEOUT_CYC cycles after START entry; lines released.
- Assert reset_n=0 during DATA bit 4. Required: ps2_clk_oe=ps2_dat_oe=0 with no clock edge; after reset, a new 0x00 transfer sends parity 1 and gets done.
- Pulse tx_valid during an active transfer with 0x55. Required: ignored; the original byte completes and no second transfer starts.
- With PS2_TX_CLK_FILTER_EN, inject 2-cycle low glitches on ps2_clk_i during DATA. Required: the bit index does not advance and 0xED still transmits correctly.
